// File: rtl/key_pkg.sv
// ---------------------------------------------------------------------------
// key_pkg
// Shared definitions for the key conditioning stage of the record/playback
// piano datapath.
//   KEY_W               key vector width (fixed at 8)
//   DEB_CYCLES_DEFAULT  default stability window in clock cycles
//   key_state_t         debounce FSM state encoding
//   lowest_set()        reduces a key vector to its lowest-index pressed key,
//                       used by the monophonic build (KEY_ONEHOT_EN)
// ---------------------------------------------------------------------------
package key_pkg;

  localparam int KEY_W              = 8;
  localparam int DEB_CYCLES_DEFAULT = 50000;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HELD
  } key_state_t;

  // Two's-complement trick: v & -v isolates the least significant set bit.
  function automatic logic [KEY_W-1:0] lowest_set(input logic [KEY_W-1:0] v);
    return v & (~v + KEY_W'(1));
  endfunction

endpackage

// File: rtl/key_sync2.sv
// ---------------------------------------------------------------------------
// key_sync2
// Two-flop synchronizer bringing the asynchronous push-button levels into the
// clk domain.
// Ports:
//   clk    system clock
//   rst    asynchronous active-low reset, clears both stages
//   d_in   raw asynchronous levels
//   q_out  synchronized levels (two clk edges behind d_in)
// ---------------------------------------------------------------------------
module key_sync2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_in,
  output logic [W-1:0] q_out
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  // First stage may go metastable; the second stage gives it a full cycle
  // to resolve before anything downstream looks at it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_in;
      sync_q <= meta_q;
    end
  end

  assign q_out = sync_q;

endmodule

// File: rtl/key_debounce_ctrl.sv
// ---------------------------------------------------------------------------
// key_debounce_ctrl
// Conditions the 8 raw push-button keys into a clean debounced key vector.
// A new synchronized vector must stay unchanged for DEB_CYCLES consecutive
// cycles before it is committed to key_out, so every physical press yields
// exactly one press_pulse.
// Ports:
//   clk            system clock
//   rst            asynchronous active-low reset
//   key_raw[7:0]   raw key levels, 1 = pressed
//   en             conditioner enable; low forces IDLE and clears key_out
//   key_out[7:0]   debounced key vector
//   key_valid      high while key_out != 0
//   press_pulse    one-cycle strobe when a nonzero vector is committed
//   release_pulse  one-cycle strobe when key_out returns to zero
// Optional build macro:
//   KEY_ONEHOT_EN  monophonic mode: only the lowest-index pressed key is
//                  debounced and committed, key_out is one-hot or zero
// ---------------------------------------------------------------------------
module key_debounce_ctrl
  import key_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT,
  parameter int KEY_W      = key_pkg::KEY_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] key_raw,
  input  logic             en,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic             press_pulse,
  output logic             release_pulse
);

  localparam int             CNT_W    = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [KEY_W-1:0] sync_raw;
  logic [KEY_W-1:0] sync;

  key_state_t       state_q,   state_d;
  logic [KEY_W-1:0] cand_q,    cand_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [KEY_W-1:0] key_out_q, key_out_d;
  logic             press_q,   press_d;
  logic             release_q, release_d;

  key_sync2 #(.W(KEY_W)) u_sync (
    .clk   (clk),
    .rst   (rst),
    .d_in  (key_raw),
    .q_out (sync_raw)
  );

`ifdef KEY_ONEHOT_EN
  assign sync = lowest_set(sync_raw);
`else
  assign sync = sync_raw;
`endif

  // Next-state logic. A return of sync to the committed value is checked
  // before the candidate restart so a short glitch collapses back to the
  // committed state instead of re-debouncing (and re-pulsing) the old value.
  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    key_out_d = key_out_q;
    press_d   = 1'b0;
    release_d = 1'b0;

    if (!en) begin
      state_d   = IDLE;
      cnt_d     = '0;
      key_out_d = '0;
    end else begin
      case (state_q)
        IDLE, HELD: begin
          if (sync != key_out_q) begin
            state_d = SETTLE;
            cand_d  = sync;
            cnt_d   = '0;
          end
        end
        SETTLE: begin
          if (sync == key_out_q) begin
            state_d = (key_out_q == '0) ? IDLE : HELD;
            cnt_d   = '0;
          end else if (sync != cand_q) begin
            cand_d = sync;
            cnt_d  = '0;
          end else if (cnt_q != CNT_LAST) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            key_out_d = cand_q;
            cnt_d     = '0;
            if (cand_q != '0) begin
              press_d = 1'b1;
              state_d = HELD;
            end else begin
              release_d = 1'b1;
              state_d   = IDLE;
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // All FSM state and registered outputs update together so the pulses are
  // coincident with the key_out change.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cand_q    <= '0;
      cnt_q     <= '0;
      key_out_q <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      key_out_q <= key_out_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign key_out       = key_out_q;
  assign key_valid     = |key_out_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;

endmodule
